// File: rtl/pe_cfg_apb_master.sv
// pe_cfg_apb_master
//
// Host-side APB initiator for the pe_cell configuration/status port. It takes
// one register access at a time from a valid/ready command port and runs a
// single APB SETUP/ACCESS transfer for it. The read data, or the write
// completion, comes back on a valid/ready response port. A programmable wait
// limit aborts transfers whose pready never arrives and flags them with rsp_err.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_write/addr/wdata     command fields, captured on handshake
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata, rsp_err       read data (0 for writes/errors), timeout flag
//   busy                     transfer in SETUP or ACCESS
//   psel, penable, pwrite,
//   paddr, pwdata            APB request (all registered)
//   prdata, pready           APB completion from pe_cell
module pe_cfg_apb_master #(
  parameter int WID_PADDR = 8,
  parameter int WID_BUS   = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [WID_PADDR-1:0] cmd_addr,
  input  logic [WID_BUS-1:0]   cmd_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WID_BUS-1:0]   rsp_rdata,
  output logic                 rsp_err,
  output logic                 busy,
  output logic                 psel,
  output logic                 penable,
  output logic                 pwrite,
  output logic [WID_PADDR-1:0] paddr,
  output logic [WID_BUS-1:0]   pwdata,
  input  logic [WID_BUS-1:0]   prdata,
  input  logic                 pready
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Count value in the ACCESS cycle whose increment would reach TIMEOUT.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     wait_reg, wait_next;
  logic                 psel_next, penable_next, pwrite_next;
  logic [WID_PADDR-1:0] paddr_next;
  logic [WID_BUS-1:0]   pwdata_next;
  logic                 rsp_valid_next, rsp_err_next;
  logic [WID_BUS-1:0]   rsp_rdata_next;

  // Only one transfer may be outstanding, so a pending response blocks new commands.
  assign cmd_ready = (state_reg == IDLE) && !rsp_valid;
  assign busy      = (state_reg != IDLE);

  always_comb begin
    state_next     = state_reg;
    wait_next      = wait_reg;
    psel_next      = psel;
    penable_next   = penable;
    pwrite_next    = pwrite;
    paddr_next     = paddr;
    pwdata_next    = pwdata;
    rsp_valid_next = rsp_valid;
    rsp_err_next   = rsp_err;
    rsp_rdata_next = rsp_rdata;

    // Response fields stay put after the handshake; only valid drops.
    if (rsp_valid && rsp_ready) begin
      rsp_valid_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_next  = SETUP;
          psel_next   = 1'b1;
          pwrite_next = cmd_write;
          paddr_next  = cmd_addr;
          pwdata_next = cmd_wdata;
        end
      end
      SETUP: begin
        state_next   = ACCESS;
        penable_next = 1'b1;
        wait_next    = '0;
      end
      ACCESS: begin
        if (pready) begin
          // pready wins over a timeout landing in the same cycle.
          state_next     = IDLE;
          psel_next      = 1'b0;
          penable_next   = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_err_next   = 1'b0;
          rsp_rdata_next = pwrite ? '0 : prdata;
        end else if ((TIMEOUT > 0) && (wait_reg == CNT_LAST)) begin
          state_next     = IDLE;
          psel_next      = 1'b0;
          penable_next   = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_err_next   = 1'b1;
          rsp_rdata_next = '0;
        end else if (wait_reg != CNT_MAX) begin
          wait_next = wait_reg + 1'b1;
        end
      end
      default: begin
        state_next   = IDLE;
        psel_next    = 1'b0;
        penable_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      wait_reg  <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_reg <= state_next;
      wait_reg  <= wait_next;
      psel      <= psel_next;
      penable   <= penable_next;
      pwrite    <= pwrite_next;
      paddr     <= paddr_next;
      pwdata    <= pwdata_next;
      rsp_valid <= rsp_valid_next;
      rsp_err   <= rsp_err_next;
      rsp_rdata <= rsp_rdata_next;
    end
  end

endmodule

// File: tb/tb_pe_cfg_apb_master.sv
// tb_pe_cfg_apb_master
//
// Self-checking bench for pe_cfg_apb_master with a small wait limit so that
// timeout behaviour is reachable. Expected responses are queued when a command
// is issued and popped when the response handshake happens. Inputs are driven
// and outputs sampled on the falling edge.
module tb_pe_cfg_apb_master;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pe_cfg_apb_master #(
    .WID_PADDR(8),
    .WID_BUS  (32),
    .TIMEOUT  (TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .busy     (busy),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One command from handshake to response consumption. waits = ACCESS cycles
  // with pready low before pready rises; waits >= TO ends in a timeout.
  // stall = cycles rsp_ready is held low. If pre is set, the next command is
  // presented during the stall so it must be held off until the response clears.
  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                      input int waits, input logic [31:0] rd, input int stall,
                      input bit pre, input logic pwr, input logic [7:0] pad,
                      input logic [31:0] pwd);
    rsp_t e, got;
    int   n;
    bit   to;
    to      = (waits >= TO);
    e.err   = to;
    e.rdata = (to || wr) ? 32'h0 : rd;

    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    chk("cmd_ready_idle", cmd_ready, 1);
    exp_q.push_back(e);
    @(negedge clk);
    // SETUP; scramble the command bus to prove the fields were latched.
    cmd_valid = 1'b0;
    cmd_addr  = 8'($urandom);
    cmd_wdata = $urandom;
    cmd_write = ~wr;
    chk("setup_psel_penable", {psel, penable}, 2'b10);
    chk("setup_busy", busy, 1);
    chk("setup_paddr", paddr, addr);
    chk("setup_pwrite", pwrite, wr);
    chk("setup_pwdata", pwdata, wd);
    @(negedge clk);
    n = 0;
    while (psel && penable && n < 40) begin
      chk("access_paddr", paddr, addr);
      pready = (n == waits);
      prdata = pready ? rd : $urandom;
      n++;
      @(negedge clk);
    end
    pready = 1'b0;
    prdata = $urandom;
    chk("access_cycles", n, to ? TO : waits + 1);
    chk("done_psel_penable_busy", {psel, penable, busy}, 3'b000);
    chk("rsp_valid_set", rsp_valid, 1);

    if (pre) begin
      cmd_valid = 1'b1;
      cmd_write = pwr;
      cmd_addr  = pad;
      cmd_wdata = pwd;
    end
    for (int s = 0; s < stall; s++) begin
      rsp_ready = 1'b0;
      chk("stall_rsp_valid", rsp_valid, 1);
      chk("stall_cmd_ready", cmd_ready, 0);
      chk("stall_rsp_rdata", rsp_rdata, e.rdata);
      chk("stall_rsp_err", rsp_err, e.err);
      @(negedge clk);
    end

    rsp_ready = 1'b1;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      got = exp_q.pop_front();
      chk("rsp_rdata", rsp_rdata, got.rdata);
      chk("rsp_err", rsp_err, got.err);
    end
    $display("xfer %s addr=%02h wdata=%08h waits=%0d rdata=%08h err=%0b",
             wr ? "WR" : "RD", addr, wd, waits, rsp_rdata, rsp_err);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_clear", rsp_valid, 0);
    chk("cmd_ready_after_rsp", cmd_ready, 1);
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = 8'h0;
    cmd_wdata = 32'h0;
    rsp_ready = 1'b0;
    prdata    = 32'h0;
    pready    = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_ctrl", {psel, penable, pwrite, busy, rsp_valid, rsp_err}, 6'b0);
    chk("reset_paddr", paddr, 0);
    chk("reset_pwdata", pwdata, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);

    // Directed cases
    xfer(1'b1, 8'h04, 32'hDEADBEEF, 0, 32'h0,        0, 1'b0, 1'b0, 8'h0, 32'h0);
    xfer(1'b0, 8'h10, 32'h0,        3, 32'h000000A5, 0, 1'b0, 1'b0, 8'h0, 32'h0);
    xfer(1'b0, 8'h08, 32'h0,        4, 32'h00000077, 0, 1'b0, 1'b0, 8'h0, 32'h0);
    xfer(1'b0, 8'h0C, 32'h0,        3, 32'h00005A5A, 0, 1'b0, 1'b0, 8'h0, 32'h0);
    xfer(1'b1, 8'h18, 32'h12345678, 9, 32'h0,        0, 1'b0, 1'b0, 8'h0, 32'h0);
    // Response backpressure with the next command already waiting
    xfer(1'b1, 8'h30, 32'h11112222, 0, 32'h0,        5, 1'b1, 1'b0, 8'h34, 32'h0);
    xfer(1'b0, 8'h34, 32'h0,        1, 32'hCAFEF00D, 0, 1'b0, 1'b0, 8'h0, 32'h0);

    // Random mix of reads/writes, wait states and timeouts
    for (int i = 0; i < 6; i++) begin
      xfer(1'($urandom), 8'($urandom), $urandom, int'($urandom_range(0, 5)), $urandom,
           int'($urandom_range(0, 2)), 1'b0, 1'b0, 8'h0, 32'h0);
    end

    // Reset in the middle of ACCESS
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 8'h20;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("mid_access_psel_penable", {psel, penable}, 2'b11);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_outputs", {psel, penable, busy, rsp_valid}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_cmd_ready", cmd_ready, 1);
    xfer(1'b0, 8'h20, 32'h0, 1, 32'h0BADCAFE, 0, 1'b0, 1'b0, 8'h0, 32'h0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
